// File: rtl/instr_enc_pkg.sv
// Shared opcode constants, FSM state encoding and field-to-word helpers for instr_encoder.
package instr_enc_pkg;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_BAD  = 2'b11;
  localparam logic [3:0] COND_AL = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } enc_state_t;

  // Branches carry a 24-bit offset in place of Rn/Rd/src2, and funct[4] becomes the link bit.
  function automatic logic [31:0] encode_word(
    input logic [3:0]  cond,
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [23:0] src
  );
    if (op == OP_BR) begin
      return {cond, 2'b10, 1'b1, funct[4], src};
    end else begin
      return {cond, op, funct, rn, rd, src[11:0]};
    end
  endfunction

  function automatic logic is_illegal(
    input logic [1:0]  op,
    input logic [5:0]  funct,
    input logic [23:0] src
  );
    return (op == OP_BAD) || ((op == OP_MEM) && funct[5] && src[4]);
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Word FIFO between the encoder and the instruction-memory write port; the head is visible
// combinationally so the write port can present it the cycle after a push.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // The extra pointer bit separates "wrapped once" (full) from "equal" (empty).
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes instruction field requests, queues the words and writes them to
// sequential instruction-memory addresses. Define ENC_CHECK_EN to drop and count illegal requests.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_last,
  input  logic [3:0]  req_cond,
  input  logic [1:0]  req_op,
  input  logic [5:0]  req_funct,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [23:0] req_src,
  output logic        im_we,
  input  logic        im_wr_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt
);

  enc_state_t  r_state;
  enc_state_t  w_state_next;
  logic [31:0] r_addr;
  logic [31:0] w_word;
  logic [31:0] w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_wr_hs;
  logic        w_in_run;
  logic        w_draining;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_draining = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign w_accept   = req_valid && w_in_run && !w_full;
  assign w_wr_hs    = im_we && im_wr_ready;
  assign w_word     = encode_word(req_cond, req_op, req_funct, req_rn, req_rd, req_src);

`ifdef ENC_CHECK_EN
  logic       w_illegal;
  logic [7:0] r_err_cnt;

  assign w_illegal = is_illegal(req_op, req_funct, req_src);
  assign w_push    = w_accept && !w_illegal;
  assign err_cnt   = r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_accept && w_illegal && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
`else
  assign w_push  = w_accept;
  assign err_cnt = 8'd0;
`endif

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_wr_hs),
    .wdata (w_word),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A dropped final request still ends the program, so req_last is taken on accept, not push.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_RUN;
      ST_RUN:   if (w_accept && req_last) w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_empty) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_in_run && !w_full;
    im_we     = w_draining && !w_empty;
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    im_addr   = r_addr;
    im_wdata  = im_we ? w_head : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= BASE_ADDR;
    end else if (r_state == ST_DONE) begin
      r_addr <= BASE_ADDR;
    end else if (w_wr_hs) begin
      r_addr <= r_addr + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed scoreboard bench for instr_encoder; expected words/addresses are queued on each
// accepted request and retired by a monitor on every instruction-memory write handshake.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        req_valid;
  logic        req_ready;
  logic        req_last;
  logic [3:0]  req_cond;
  logic [1:0]  req_op;
  logic [5:0]  req_funct;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [23:0] req_src;
  logic        im_we;
  logic        im_wr_ready;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_addr;
  logic [31:0] first_word;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_last    (req_last),
    .req_cond    (req_cond),
    .req_op      (req_op),
    .req_funct   (req_funct),
    .req_rn      (req_rn),
    .req_rd      (req_rd),
    .req_src     (req_src),
    .im_we       (im_we),
    .im_wr_ready (im_wr_ready),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .busy        (busy),
    .done        (done),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_encode(input logic [3:0] cond, input logic [1:0] op,
                                            input logic [5:0] funct, input logic [3:0] rn,
                                            input logic [3:0] rd, input logic [23:0] src);
    logic [31:0] w;
    w = 32'd0;
    w[31:28] = cond;
    if (op == 2'b10) begin
      w[27:24] = {3'b101, funct[4]};
      w[23:0]  = src;
    end else begin
      w[27:26] = op;
      w[25:20] = funct;
      w[19:16] = rn;
      w[15:12] = rd;
      w[11:0]  = src[11:0];
    end
    return w;
  endfunction

  // Monitor: one line per retired write.
  always @(negedge clk) begin
    if (!reset && im_we && im_wr_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'(sb_q.size()), 64'd1);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("write", {im_addr, im_wdata}, e);
        $display("write addr=%h data=%h expected addr=%h data=%h", im_addr, im_wdata, e[63:32], e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] src,
                      input logic last, input logic pushes, input logic [31:0] exp_word);
    int cyc;
    req_cond = cond; req_op = op; req_funct = funct; req_rn = rn; req_rd = rd;
    req_src = src; req_last = last; req_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'(req_ready), 64'd1);
    end else begin
      if (pushes) begin
        sb_q.push_back({exp_addr, exp_word});
        exp_addr = exp_addr + 32'd4;
      end
      $display("request op=%b funct=%h src=%h last=%b pushed=%b", op, funct, src, last, pushes);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_pulse"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_addr_base"}, 64'(im_addr), 64'(BASE));
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    exp_addr = BASE;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
    req_cond = 4'h0; req_op = 2'b00; req_funct = 6'h00; req_rn = 4'h0; req_rd = 4'h0;
    req_src = 24'h0; im_wr_ready = 1'b1; exp_addr = BASE;
    repeat (3) @(posedge clk);
    #1;
    check("rst_im_we", 64'(im_we), 64'd0);
    check("rst_im_addr", 64'(im_addr), 64'(BASE));
    check("rst_im_wdata", 64'(im_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_req_ready", 64'(req_ready), 64'd0);

    // 1: single ADD
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    send(COND_AL, OP_DP, 6'b101000, 4'd2, 4'd1, 24'h000005, 1'b1, 1'b1, 32'hE2821005);
    wait_done("t1");

    // 2: LDR then branch back
    pulse_start();
    send(COND_AL, OP_MEM, 6'b011001, 4'd4, 4'd3, 24'h000008, 1'b0, 1'b1, 32'hE5943008);
    send(COND_AL, OP_BR, 6'b000000, 4'd0, 4'd0, 24'hFFFFFE, 1'b1, 1'b1, 32'hEAFFFFFE);
    wait_done("t2");

    // 3: backpressure fills the FIFO
    im_wr_ready = 1'b0;
    pulse_start();
    first_word = tb_encode(COND_AL, OP_DP, 6'h04, 4'd0, 4'd1, 24'h000000);
    for (int i = 0; i < 4; i++) begin
      send(COND_AL, OP_DP, 6'(6'h04 + i), 4'(i), 4'(i + 1), 24'(24'h10 * i), 1'b0, 1'b1,
           tb_encode(COND_AL, OP_DP, 6'(6'h04 + i), 4'(i), 4'(i + 1), 24'(24'h10 * i)));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_full_ready_low", 64'(req_ready), 64'd0);
      check("t3_hold_we", 64'(im_we), 64'd1);
      check("t3_hold_word", 64'(im_wdata), 64'(first_word));
      check("t3_hold_addr", 64'(im_addr), 64'(BASE));
    end
    @(posedge clk); #1;
    im_wr_ready = 1'b1;
    send(4'h1, OP_MEM, 6'b011000, 4'd5, 4'd6, 24'h000ABC, 1'b1, 1'b1,
         tb_encode(4'h1, OP_MEM, 6'b011000, 4'd5, 4'd6, 24'h000ABC));
    wait_done("t3");

    // 4: illegal request between two legal ones
    pulse_start();
    send(COND_AL, OP_DP, 6'b000100, 4'd7, 4'd8, 24'h0000FF, 1'b0, 1'b1,
         tb_encode(COND_AL, OP_DP, 6'b000100, 4'd7, 4'd8, 24'h0000FF));
`ifdef ENC_CHECK_EN
    send(COND_AL, OP_BAD, 6'b000000, 4'd1, 4'd1, 24'h000001, 1'b0, 1'b0, 32'd0);
    send(COND_AL, OP_MEM, 6'b111001, 4'd2, 4'd2, 24'h000010, 1'b0, 1'b0, 32'd0);
`else
    send(COND_AL, OP_BAD, 6'b000000, 4'd1, 4'd1, 24'h000001, 1'b0, 1'b1,
         tb_encode(COND_AL, OP_BAD, 6'b000000, 4'd1, 4'd1, 24'h000001));
`endif
    send(4'h0, OP_BR, 6'b010000, 4'd0, 4'd0, 24'h000010, 1'b1, 1'b1,
         tb_encode(4'h0, OP_BR, 6'b010000, 4'd0, 4'd0, 24'h000010));
    wait_done("t4");
`ifdef ENC_CHECK_EN
    check("t4_err_cnt", 64'(err_cnt), 64'd2);
`else
    check("t4_err_cnt", 64'(err_cnt), 64'd0);
`endif

    // 5: reset with words pending
    im_wr_ready = 1'b0;
    pulse_start();
    send(COND_AL, OP_DP, 6'b001000, 4'd1, 4'd2, 24'h000003, 1'b0, 1'b1, 32'd0);
    send(COND_AL, OP_DP, 6'b001000, 4'd3, 4'd4, 24'h000004, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    check("t5_pending_we", 64'(im_we), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_we", 64'(im_we), 64'd0);
    check("t5_rst_addr", 64'(im_addr), 64'(BASE));
    check("t5_rst_busy", 64'(busy), 64'd0);
    sb_q.delete();
    exp_addr = BASE;
    @(posedge clk); #1;
    reset = 1'b0;
    im_wr_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_we_after", 64'(im_we), 64'd0);
    check("t5_still_idle", 64'(busy), 64'd0);

    // 6: start during RUN is ignored
    pulse_start();
    send(COND_AL, OP_DP, 6'b010010, 4'd9, 4'd10, 24'h000123, 1'b0, 1'b1,
         tb_encode(COND_AL, OP_DP, 6'b010010, 4'd9, 4'd10, 24'h000123));
    pulse_start();
    check("t6_still_run", 64'(req_ready), 64'd1);
    send(COND_AL, OP_BR, 6'b010000, 4'd0, 4'd0, 24'h800000, 1'b1, 1'b1,
         tb_encode(COND_AL, OP_BR, 6'b010000, 4'd0, 4'd0, 24'h800000));
    wait_done("t6");
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_restart", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
